// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, program memory and the PC block.
// Also holds the shared Q-cycle / execute-state encodings used on that bus.
// master = sequencer side, slave = the surrounding core / bench.

`ifndef PC_WIDTH
`define PC_WIDTH 11
`endif

`ifndef FE_STATE_BITS
`define FE_STATE_BITS 2
`define FE_Q1 2'd0
`define FE_Q2 2'd1
`define FE_Q3 2'd2
`define FE_Q4 2'd3
`endif

`ifndef EX_STATE_BITS
`define EX_STATE_BITS 5
`define EX_Q1        5'd0
`define EX_Q2        5'd1
`define EX_Q3        5'd2
`define EX_Q4_NOP    5'd3
`define EX_Q4_OPTION 5'd4
`define EX_Q4_SLEEP  5'd5
`define EX_Q4_CLRWDT 5'd6
`define EX_Q4_TRIS   5'd7
`define EX_Q4_MOVWF  5'd8
`define EX_Q4_CLRW   5'd9
`define EX_Q4_CLRF   5'd10
`define EX_Q4_MOVF   5'd11
`define EX_Q4_FSZ    5'd12
`define EX_Q4_BXF    5'd13
`define EX_Q4_BTFSX  5'd14
`define EX_Q4_RETLW  5'd15
`define EX_Q4_CALL   5'd16
`define EX_Q4_GOTO   5'd17
`define EX_Q4_MOVLW  5'd18
`define EX_Q4_ALUXLW 5'd19
`define EX_Q4_ELSE   5'd20
`endif

interface fetch_sequencer_if #(
  parameter int INSTR_WIDTH = 12
);
  logic [`PC_WIDTH-1:0]      PC;
  logic                      skip;
  logic [INSTR_WIDTH-1:0]    progData;
  logic                      wake;
  logic [`PC_WIDTH-1:0]      progAddr;
  logic [INSTR_WIDTH-1:0]    IR;
  logic [`FE_STATE_BITS-1:0] fetchState;
  logic [`EX_STATE_BITS-1:0] executeState;
  logic                      sleeping;

  modport master (
    input  PC, skip, progData, wake,
    output progAddr, IR, fetchState, executeState, sleeping
  );

  modport slave (
    output PC, skip, progData, wake,
    input  progAddr, IR, fetchState, executeState, sleeping
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Four-phase Q-cycle sequencer: latches PC into progAddr at end of Q2, loads IR at end of Q4,
// decodes IR into an EX_Q4_* code at the Q3->Q4 edge; skip during Q1 squashes IR to NOP_WORD.
// Optional macro SLEEP_HALT_EN: SLEEP parks the counter at Q1 until wake is sampled high.

module fetch_sequencer #(
  parameter int                     INSTR_WIDTH = 12,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 12'h000
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [`FE_STATE_BITS-1:0] {
    FE_S1 = `FE_Q1,
    FE_S2 = `FE_Q2,
    FE_S3 = `FE_Q3,
    FE_S4 = `FE_Q4
  } fe_state_t;

  fe_state_t                 fe_q;
  logic [`EX_STATE_BITS-1:0] ex_q;
  logic [INSTR_WIDTH-1:0]    ir_q;
  logic [`PC_WIDTH-1:0]      addr_q;

  // Priority decode of the 12-bit instruction word; unlisted patterns execute as NOP.
  function automatic logic [`EX_STATE_BITS-1:0] decode(input logic [11:0] w);
    logic [`EX_STATE_BITS-1:0] code;
    code = `EX_Q4_NOP;
    if      (w == 12'b0000_0000_0010)                                code = `EX_Q4_OPTION;
    else if (w == 12'b0000_0000_0011)                                code = `EX_Q4_SLEEP;
    else if (w == 12'b0000_0000_0100)                                code = `EX_Q4_CLRWDT;
    else if (w >= 12'b0000_0000_0101 && w <= 12'b0000_0000_0111)     code = `EX_Q4_TRIS;
    else if (w ==? 12'b0000_001?_????)                               code = `EX_Q4_MOVWF;
    else if (w == 12'b0000_0100_0000)                                code = `EX_Q4_CLRW;
    else if (w ==? 12'b0000_011?_????)                               code = `EX_Q4_CLRF;
    else if (w ==? 12'b0000_????_????)                               code = `EX_Q4_NOP;
    else if (w ==? 12'b0010_00??_????)                               code = `EX_Q4_MOVF;
    else if (w ==? 12'b0010_11??_???? || w ==? 12'b0011_11??_????)   code = `EX_Q4_FSZ;
    else if (w ==? 12'b00??_????_????)                               code = `EX_Q4_ELSE;
    else if (w ==? 12'b010?_????_????)                               code = `EX_Q4_BXF;
    else if (w ==? 12'b011?_????_????)                               code = `EX_Q4_BTFSX;
    else if (w ==? 12'b1000_????_????)                               code = `EX_Q4_RETLW;
    else if (w ==? 12'b1001_????_????)                               code = `EX_Q4_CALL;
    else if (w ==? 12'b101?_????_????)                               code = `EX_Q4_GOTO;
    else if (w ==? 12'b1100_????_????)                               code = `EX_Q4_MOVLW;
    else                                                             code = `EX_Q4_ALUXLW;
    return code;
  endfunction

`ifdef SLEEP_HALT_EN
  logic sleep_q;

  // Q-cycle FSM with fetch/decode side effects; a parked core only watches wake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_q    <= FE_S1;
      ex_q    <= `EX_Q1;
      ir_q    <= NOP_WORD;
      addr_q  <= '0;
      sleep_q <= 1'b0;
    end else if (sleep_q) begin
      if (bus.wake) sleep_q <= 1'b0;
    end else begin
      case (fe_q)
        FE_S1: begin
          fe_q <= FE_S2;
          ex_q <= `EX_Q2;
          if (bus.skip) ir_q <= NOP_WORD;
        end
        FE_S2: begin
          fe_q   <= FE_S3;
          ex_q   <= `EX_Q3;
          addr_q <= bus.PC;
        end
        FE_S3: begin
          fe_q <= FE_S4;
          ex_q <= decode(ir_q[11:0]);
        end
        FE_S4: begin
          fe_q <= FE_S1;
          ex_q <= `EX_Q1;
          // The following word is already fetched; load it so wake resumes past the SLEEP.
          ir_q <= bus.progData;
          if (ex_q == `EX_Q4_SLEEP) sleep_q <= 1'b1;
        end
        default: begin
          fe_q <= FE_S1;
          ex_q <= `EX_Q1;
        end
      endcase
    end
  end

  assign bus.sleeping = sleep_q;
`else
  logic unused_wake;
  assign unused_wake = bus.wake;

  // Q-cycle FSM with fetch/decode side effects; SLEEP decodes but never halts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_q   <= FE_S1;
      ex_q   <= `EX_Q1;
      ir_q   <= NOP_WORD;
      addr_q <= '0;
    end else begin
      case (fe_q)
        FE_S1: begin
          fe_q <= FE_S2;
          ex_q <= `EX_Q2;
          if (bus.skip) ir_q <= NOP_WORD;
        end
        FE_S2: begin
          fe_q   <= FE_S3;
          ex_q   <= `EX_Q3;
          addr_q <= bus.PC;
        end
        FE_S3: begin
          fe_q <= FE_S4;
          ex_q <= decode(ir_q[11:0]);
        end
        FE_S4: begin
          fe_q <= FE_S1;
          ex_q <= `EX_Q1;
          ir_q <= bus.progData;
        end
        default: begin
          fe_q <= FE_S1;
          ex_q <= `EX_Q1;
        end
      endcase
    end
  end

  assign bus.sleeping = 1'b0;
`endif

  assign bus.fetchState   = fe_q;
  assign bus.executeState = ex_q;
  assign bus.IR           = ir_q;
  assign bus.progAddr     = addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, pipeline fill, free run, skip, decode sweep,
// SLEEP handling (parks only when SLEEP_HALT_EN is defined) and mid-cycle reset.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_fetch_sequencer;

  localparam logic [1:0] FE_Q1 = 2'd0;
  localparam logic [1:0] FE_Q2 = 2'd1;
  localparam logic [1:0] FE_Q3 = 2'd2;
  localparam logic [1:0] FE_Q4 = 2'd3;

  localparam logic [4:0] EX_Q1     = 5'd0;
  localparam logic [4:0] EX_Q2     = 5'd1;
  localparam logic [4:0] EX_Q3     = 5'd2;
  localparam logic [4:0] EX_NOP    = 5'd3;
  localparam logic [4:0] EX_OPTION = 5'd4;
  localparam logic [4:0] EX_SLEEP  = 5'd5;
  localparam logic [4:0] EX_MOVWF  = 5'd8;
  localparam logic [4:0] EX_FSZ    = 5'd12;
  localparam logic [4:0] EX_BTFSX  = 5'd14;
  localparam logic [4:0] EX_CALL   = 5'd16;
  localparam logic [4:0] EX_GOTO   = 5'd17;
  localparam logic [4:0] EX_MOVLW  = 5'd18;
  localparam logic [4:0] EX_ELSE   = 5'd20;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_sequencer_if #(.INSTR_WIDTH(12)) bus ();

  localparam int PC_W = $bits(bus.PC);

  fetch_sequencer #(.INSTR_WIDTH(12), .NOP_WORD(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction cycle, entered on the falling edge of the previous Q4.
  task automatic exec_cycle(input int pc, input logic [11:0] data, input bit do_skip,
                            input logic [11:0] exp_ir, input logic [4:0] exp_q4, input string tag);
    bus.PC = PC_W'(pc);
    @(negedge clk);
    chk({tag, "_fe_q1"}, 32'(bus.fetchState), 32'(FE_Q1));
    bus.skip = do_skip;
    @(negedge clk);
    bus.skip = 1'b0;
    chk({tag, "_ir"}, 32'(bus.IR), 32'(exp_ir));
    @(negedge clk);
    chk({tag, "_addr"}, 32'(bus.progAddr), pc);
    bus.progData = data;
    @(negedge clk);
    chk({tag, "_ex_q4"}, 32'(bus.executeState), 32'(exp_q4));
  endtask

  initial begin
    int q1_seen;
    logic [4:0] exp_ex;

    rst          = 1'b1;
    bus.PC       = '0;
    bus.skip     = 1'b0;
    bus.progData = 12'hC5A;
    bus.wake     = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_fe",    32'(bus.fetchState),   32'(FE_Q1));
    chk("rst_ex",    32'(bus.executeState), 32'(EX_Q1));
    chk("rst_ir",    32'(bus.IR),           32'h000);
    chk("rst_addr",  32'(bus.progAddr),     0);
    chk("rst_sleep", 32'(bus.sleeping),     0);

    // Pipeline fill: first instruction cycle executes NOP while address 0 is fetched
    rst = 1'b0;
    @(negedge clk);
    chk("fill_fe_q2", 32'(bus.fetchState), 32'(FE_Q2));
    @(negedge clk);
    chk("fill_addr", 32'(bus.progAddr), 0);
    @(negedge clk);
    chk("fill_ex_q4", 32'(bus.executeState), 32'(EX_NOP));
    chk("fill_ir",    32'(bus.IR),           32'h000);

    exec_cycle(1, 12'hA23, 1'b0, 12'hC5A, EX_MOVLW, "movlw");

    // Free run: IR keeps reloading 12'hA23 (GOTO) every Q4
    q1_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("run_fe", 32'(bus.fetchState), i % 4);
      if (bus.fetchState == FE_Q1) q1_seen++;
      case (i % 4)
        0:       exp_ex = EX_Q1;
        1:       exp_ex = EX_Q2;
        2:       exp_ex = EX_Q3;
        default: exp_ex = EX_GOTO;
      endcase
      chk("run_ex", 32'(bus.executeState), 32'(exp_ex));
    end
    chk("run_q1_count", q1_seen, 4);

    // Skip squashes the GOTO; next cycle the unsquashed GOTO decodes normally
    exec_cycle(2,  12'hA23, 1'b1, 12'h000, EX_NOP,    "skip");
    exec_cycle(3,  12'h025, 1'b0, 12'hA23, EX_GOTO,   "goto");
    exec_cycle(4,  12'h2E1, 1'b0, 12'h025, EX_MOVWF,  "movwf");
    exec_cycle(5,  12'h6A4, 1'b0, 12'h2E1, EX_FSZ,    "fsz");
    exec_cycle(6,  12'h905, 1'b0, 12'h6A4, EX_BTFSX,  "btfsx");
    exec_cycle(7,  12'h1C3, 1'b0, 12'h905, EX_CALL,   "call");
    exec_cycle(8,  12'h001, 1'b0, 12'h1C3, EX_ELSE,   "else");
    exec_cycle(9,  12'h002, 1'b0, 12'h001, EX_NOP,    "nop001");
    exec_cycle(10, 12'h003, 1'b0, 12'h002, EX_OPTION, "option");
    exec_cycle(11, 12'hC5A, 1'b0, 12'h003, EX_SLEEP,  "sleep");

`ifdef SLEEP_HALT_EN
    @(negedge clk);
    chk("park_sleeping", 32'(bus.sleeping),     1);
    chk("park_fe",       32'(bus.fetchState),   32'(FE_Q1));
    chk("park_ex",       32'(bus.executeState), 32'(EX_Q1));
    chk("park_ir",       32'(bus.IR),           32'hC5A);
    bus.progData = 12'hFFF;
    bus.PC       = PC_W'(12'h055);
    bus.skip     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_sleeping", 32'(bus.sleeping),   1);
      chk("hold_fe",       32'(bus.fetchState), 32'(FE_Q1));
    end
    chk("hold_ir",   32'(bus.IR),       32'hC5A);
    chk("hold_addr", 32'(bus.progAddr), 11);
    bus.skip = 1'b0;
    bus.wake = 1'b1;
    @(negedge clk);
    bus.wake = 1'b0;
    chk("wake_sleeping", 32'(bus.sleeping),   0);
    chk("wake_fe",       32'(bus.fetchState), 32'(FE_Q1));
`else
    bus.wake = 1'b1;
    @(negedge clk);
    bus.wake = 1'b0;
    chk("nohalt_sleeping", 32'(bus.sleeping),   0);
    chk("nohalt_fe",       32'(bus.fetchState), 32'(FE_Q1));
    chk("nohalt_ir",       32'(bus.IR),         32'hC5A);
`endif
    @(negedge clk);
    chk("resume_fe_q2",    32'(bus.fetchState), 32'(FE_Q2));
    chk("resume_sleeping", 32'(bus.sleeping),   0);
    @(negedge clk);
    @(negedge clk);
    chk("resume_ex_q4", 32'(bus.executeState), 32'(EX_MOVLW));

    // Reset in the middle of Q3 aborts the instruction at once
    bus.progData = 12'hC5A;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_fe", 32'(bus.fetchState), 32'(FE_Q3));
    rst = 1'b1;
    #1;
    chk("midrst_fe",    32'(bus.fetchState),   32'(FE_Q1));
    chk("midrst_ex",    32'(bus.executeState), 32'(EX_Q1));
    chk("midrst_ir",    32'(bus.IR),           32'h000);
    chk("midrst_addr",  32'(bus.progAddr),     0);
    chk("midrst_sleep", 32'(bus.sleeping),     0);
    @(negedge clk);
    @(negedge clk);
    chk("inrst_ex", 32'(bus.executeState), 32'(EX_Q1));
    chk("inrst_fe", 32'(bus.fetchState),   32'(FE_Q1));
    rst    = 1'b0;
    bus.PC = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("postrst_ex_q4", 32'(bus.executeState), 32'(EX_NOP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
